ysyx_23060180_mem_responder: RTL and testbench

YSYX_23060180_MEM_RESPONDER -- requirements
Module: ysyx_23060180_mem_responder

---
 rtl/ysyx_23060180_mem_responder.sv | 67 ++++++
 tb/tb_ysyx_23060180_mem_responder.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ysyx_23060180_mem_responder.sv
// ysyx_23060180_mem_responder: single-cycle word memory with sized, write-first byte-lane writes and registered reads.
// Define YSYX_23060180_MEM_BOUND_CHECK_EN to flag out-of-range accesses instead of wrapping the offset.
module ysyx_23060180_mem_responder #(
  parameter logic [31:0] MEM_BASE = 32'h80000000,
  parameter int          ADDR_W   = 14
) (
  input  logic        clk,
  input  logic        rstn_in,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_raddr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wbit_en,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       offset, old_word, new_word, wdata_sh, mask, rdata_d, rdata_q;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic              in_range, mis, wr_en, rvalid_d, rvalid_q, err_d, err_q;
`ifdef YSYX_23060180_MEM_BOUND_CHECK_EN
  assign in_range = offset[31:ADDR_W+2] == '0;
`else
  logic unused_hi;
  assign in_range  = 1'b1;
  assign unused_hi = ^offset[31:ADDR_W+2];
`endif
  always_comb begin
    offset   = mem_raddr - MEM_BASE;
    idx      = offset[ADDR_W+1:2];
    lane     = mem_raddr[1:0];
    be       = mem_wbit_en == 4'd1 ? 4'b0001 << lane :
               mem_wbit_en == 4'd2 ? 4'b0011 << lane :
               mem_wbit_en == 4'd4 ? 4'b1111 : 4'b0000;
    mis      = mem_wr && ((mem_wbit_en == 4'd2 && lane[0]) || (mem_wbit_en == 4'd4 && lane != 2'd0));
    wr_en    = mem_wr && in_range && !mis && be != 4'b0000;
    wdata_sh = mem_wdata << {lane, 3'b000};
    mask     = wr_en ? {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}} : 32'h0;
    old_word = mem[idx];
    // merged word doubles as the read source so same-edge reads see the new bytes
    new_word = (old_word & ~mask) | (wdata_sh & mask);
    rdata_d  = !mem_rd ? rdata_q : !in_range ? 32'hDEADBEEF : new_word >> {lane, 3'b000};
    rvalid_d = mem_rd;
    err_d    = err_q | mis | (!in_range && (mem_rd || mem_wr));
  end
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= new_word;
  end
  assign mem_rdata  = rdata_q;
  assign mem_rvalid = rvalid_q;
  assign mem_err    = err_q;
endmodule

// File: tb/tb_ysyx_23060180_mem_responder.sv
// tb_ysyx_23060180_mem_responder: directed scoreboard bench for the memory responder (default wrap build).
module tb_ysyx_23060180_mem_responder;
  logic        clk = 1'b0;
  logic        rstn_in = 1'b0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [31:0] mem_raddr = 32'h0, mem_wdata = 32'h0;
  logic [3:0]  mem_wbit_en = 4'h0;
  logic [31:0] mem_rdata;
  logic        mem_rvalid, mem_err;
  logic [31:0] model [16384];
  logic [31:0] sb [$];
  logic [31:0] held = 32'h0;
  logic        err_m = 1'b0;
  int          checks = 0, failures = 0;

  ysyx_23060180_mem_responder dut (
    .clk(clk), .rstn_in(rstn_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_raddr(mem_raddr), .mem_wdata(mem_wdata), .mem_wbit_en(mem_wbit_en),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] sz);
    logic [31:0] off, w;
    logic [13:0] i;
    int          l;
    mem_rd = rd; mem_wr = wr; mem_raddr = a; mem_wdata = wd; mem_wbit_en = sz;
    off = a - 32'h80000000;
    i   = off[15:2];
    l   = int'(a[1:0]);
    w   = model[i];
    if (wr) begin
      if (sz == 4'd1) w[8*l +: 8] = wd[7:0];
      else if (sz == 4'd2) begin
        if (l % 2 == 1) err_m = 1'b1;
        else w[8*l +: 16] = wd[15:0];
      end else if (sz == 4'd4) begin
        if (l != 0) err_m = 1'b1;
        else w = wd;
      end
      model[i] = w;
    end
    if (rd) sb.push_back(w >> (8 * l));
    @(posedge clk);
    #1;
    chk("rvalid", {31'b0, mem_rvalid}, {31'b0, rd});
    if (rd) held = sb.pop_front();
    chk("rdata", mem_rdata, held);
    chk("err", {31'b0, mem_err}, {31'b0, err_m});
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_rvalid", {31'b0, mem_rvalid}, 32'h0);
    chk("rst_err", {31'b0, mem_err}, 32'h0);
    @(negedge clk);
    rstn_in = 1'b1;
    step(0, 1, 32'h80000000, 32'h12345678, 4'd4);
    step(1, 0, 32'h80000000, 32'h0, 4'd0);
    chk("word_rd", mem_rdata, 32'h12345678);
    step(0, 0, 32'h80000000, 32'h0, 4'd0);
    step(0, 1, 32'h80000003, 32'h000000AB, 4'd1);
    step(1, 0, 32'h80000003, 32'h0, 4'd0);
    chk("byte_rd", mem_rdata, 32'h000000AB);
    step(1, 0, 32'h80000000, 32'h0, 4'd0);
    chk("byte_word", mem_rdata, 32'hAB345678);
    step(0, 1, 32'h80000002, 32'hFFFF1122, 4'd2);
    step(1, 0, 32'h80000002, 32'h0, 4'd0);
    step(0, 1, 32'h80000000, 32'hFFFFFFFF, 4'd3);
    step(1, 0, 32'h80000000, 32'h0, 4'd0);
    chk("nosize_word", mem_rdata, 32'h11225678);
    step(0, 1, 32'h80000001, 32'h0000BEEF, 4'd2);
    chk("mis_half_err", {31'b0, mem_err}, 32'h1);
    step(1, 0, 32'h80000000, 32'h0, 4'd0);
    chk("mis_half_mem", mem_rdata, 32'h11225678);
    step(0, 1, 32'h80000006, 32'h55555555, 4'd4);
    step(1, 1, 32'h80000010, 32'hCAFEF00D, 4'd4);
    chk("wr_first", mem_rdata, 32'hCAFEF00D);
    step(1, 1, 32'h80000011, 32'h00000099, 4'd1);
    step(1, 0, 32'h80010000, 32'h0, 4'd0);
    step(1, 0, 32'h80000013, 32'h0, 4'd0);
    step(0, 0, 32'h0, 32'h0, 4'd0);
    chk("sticky_err", {31'b0, mem_err}, 32'h1);
    step(0, 1, 32'h80000004, 32'hA5A5A5A5, 4'd4);
    step(0, 1, 32'h80000008, 32'h3C3C3C3C, 4'd4);
    step(1, 0, 32'h80000000, 32'h0, 4'd0);
    step(1, 0, 32'h80000004, 32'h0, 4'd0);
    chk("stream_2", mem_rdata, 32'hA5A5A5A5);
    mem_rd = 1'b1; mem_raddr = 32'h80000008;
    @(posedge clk);
    #1;
    rstn_in = 1'b0; mem_rd = 1'b0;
    held = 32'h0; err_m = 1'b0;
    #1;
    chk("mid_rst_rvalid", {31'b0, mem_rvalid}, 32'h0);
    chk("mid_rst_rdata", mem_rdata, 32'h0);
    chk("mid_rst_err", {31'b0, mem_err}, 32'h0);
    @(negedge clk);
    rstn_in = 1'b1;
    step(1, 0, 32'h80000008, 32'h0, 4'd0);
    chk("retain_8", mem_rdata, 32'h3C3C3C3C);
    step(1, 0, 32'h80000000, 32'h0, 4'd0);
    step(1, 0, 32'h80000010, 32'h0, 4'd0);
    step(0, 0, 32'h0, 32'h0, 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
